// File: rtl/alarm_pkg.sv
// alarm_pkg: channel state type, BCD time increment helpers and reset time
package alarm_pkg;

    typedef enum logic [1:0] {IDLE, RING, SNOOZE} alarm_state_t;

    localparam logic [7:0] RST_HR  = 8'h07;
    localparam logic [7:0] RST_MIN = 8'h00;

    function automatic logic [7:0] bcd_hr_inc(input logic [7:0] hr);
        return (hr == 8'h23) ? 8'h00 :
               (hr[3:0] == 4'd9) ? {hr[7:4] + 4'd1, 4'd0} : {hr[7:4], hr[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_min_inc(input logic [7:0] mn);
        return (mn == 8'h59) ? 8'h00 :
               (mn[3:0] == 4'd9) ? {mn[7:4] + 4'd1, 4'd0} : {mn[7:4], mn[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// alarm_channel: one alarm time, its comparator, ring/snooze FSM and seconds counter
module alarm_channel
    import alarm_pkg::*;
#(
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic       alarm_clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       match_en,
    input  logic [7:0] cur_hr,
    input  logic [7:0] cur_min,
    input  logic       inc_hr,
    input  logic       inc_min,
    input  logic       en,
    input  logic       stop,
    input  logic       snooze,
    output logic [7:0] hr_o,
    output logic [7:0] min_o,
    output logic       ringing_o
);

    localparam int SNOOZE_SECS = SNOOZE_MIN * 60;
    localparam int CNT_MAX     = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
    localparam int CW          = $clog2(CNT_MAX + 1);

    alarm_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    hr_q, hr_d, min_q, min_d;
    logic          ring_q, ring_d, match, last_tick;

    // Edits, time match and ring/snooze transitions; the counter holds seconds left in the current phase
    always_comb begin
        hr_d      = inc_hr ? bcd_hr_inc(hr_q) : hr_q;
        min_d     = inc_min ? bcd_min_inc(min_q) : min_q;
        match     = match_en & (cur_hr == hr_q) & (cur_min == min_q);
        last_tick = tick_1hz & (cnt_q == CW'(1));
        state_d   = state_q;
        cnt_d     = cnt_q;
        if (!en || stop) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == RING) begin
            if (snooze) begin
                state_d = SNOOZE;
                cnt_d   = CW'(SNOOZE_SECS);
            end else if (tick_1hz) begin
                state_d = last_tick ? IDLE : RING;
                cnt_d   = cnt_q - CW'(1);
            end
        end else if (state_q == SNOOZE) begin
            if (tick_1hz) begin
                state_d = (last_tick || match) ? RING : SNOOZE;
                cnt_d   = (last_tick || match) ? CW'(RING_SECS) : cnt_q - CW'(1);
            end
        end else if (match) begin
            state_d = RING;
            cnt_d   = CW'(RING_SECS);
        end
        ring_d = (state_d == RING);
    end

    // Channel state, counter and stored time
    always_ff @(posedge alarm_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hr_q    <= RST_HR;
            min_q   <= RST_MIN;
            ring_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hr_q    <= hr_d;
            min_q   <= min_d;
            ring_q  <= ring_d;
        end
    end

    assign hr_o      = hr_q;
    assign min_o     = min_q;
    assign ringing_o = ring_q;

endmodule

// File: rtl/alarm_bank.sv
// alarm_bank: multi-channel BCD alarm with shared edit controls, display mux and buzzer tone
module alarm_bank
    import alarm_pkg::*;
#(
    parameter  int NUM_ALARMS = 4,
    parameter  int RING_SECS  = 60,
    parameter  int SNOOZE_MIN = 5,
    parameter  int TONE_DIV   = 2,
    localparam int SW         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  alarm_clk,
    input  logic                  rst_n,
    input  logic                  tick_1hz,
    input  logic [3:0]            hr_high_i,
    input  logic [3:0]            hr_low_i,
    input  logic [3:0]            min_high_i,
    input  logic [3:0]            min_low_i,
    input  logic [3:0]            sec_high_i,
    input  logic [3:0]            sec_low_i,
    input  logic [SW-1:0]         sel_i,
    input  logic                  set_mode_i,
    input  logic                  turn_i,
    input  logic                  change_i,
    input  logic [NUM_ALARMS-1:0] en_i,
    input  logic                  stop_i,
    input  logic                  snooze_i,
    output logic                  alarm_o,
    output logic [NUM_ALARMS-1:0] ringing_o,
    output logic [3:0]            hr_high_o,
    output logic [3:0]            hr_low_o,
    output logic [3:0]            min_high_o,
    output logic [3:0]            min_low_o,
    output logic                  led_hr_o,
    output logic                  led_min_o
);

    localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    logic                       change_q, change_d, set_mode_q, set_mode_d;
    logic                       alarm_q, alarm_d, edit, match_en;
    logic [TW-1:0]              tone_q, tone_d;
    logic [NUM_ALARMS-1:0][7:0] hr, mn;
    logic [7:0]                 disp_hr, disp_min;

    // Edit strobe fires on a change_i transition only while edit mode is steady
    always_comb begin
        change_d   = change_i;
        set_mode_d = set_mode_i;
        edit       = set_mode_i & (set_mode_i == set_mode_q) & (change_i != change_q);
        match_en   = tick_1hz & ~set_mode_i & ({sec_high_i, sec_low_i} == 8'h00);
    end

    genvar k;
    generate
        for (k = 0; k < NUM_ALARMS; k++) begin : g_ch
            alarm_channel #(
                .RING_SECS (RING_SECS),
                .SNOOZE_MIN(SNOOZE_MIN)
            ) u_ch (
                .alarm_clk(alarm_clk),
                .rst_n    (rst_n),
                .tick_1hz (tick_1hz),
                .match_en (match_en),
                .cur_hr   ({hr_high_i, hr_low_i}),
                .cur_min  ({min_high_i, min_low_i}),
                .inc_hr   (edit & turn_i & (sel_i == SW'(k))),
                .inc_min  (edit & ~turn_i & (sel_i == SW'(k))),
                .en       (en_i[k]),
                .stop     (stop_i),
                .snooze   (snooze_i),
                .hr_o     (hr[k]),
                .min_o    (mn[k]),
                .ringing_o(ringing_o[k])
            );
        end
    endgenerate

    // Display shows the selected channel; an out-of-range select shows 00:00
    always_comb begin
        disp_hr  = '0;
        disp_min = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (sel_i == SW'(i)) begin
                disp_hr  = hr[i];
                disp_min = mn[i];
            end
        end
    end

    // Tone divider runs only while some channel rings, otherwise it and the buzzer are held at 0
    always_comb begin
        tone_d  = (|ringing_o && tone_q != TW'(TONE_DIV - 1)) ? tone_q + TW'(1) : '0;
        alarm_d = |ringing_o & (alarm_q ^ (tone_q == TW'(TONE_DIV - 1)));
    end

    // Control history and tone registers; history tracks the inputs through reset
    always_ff @(posedge alarm_clk or negedge rst_n) begin
        if (!rst_n) begin
            change_q   <= change_i;
            set_mode_q <= set_mode_i;
            tone_q     <= '0;
            alarm_q    <= 1'b0;
        end else begin
            change_q   <= change_d;
            set_mode_q <= set_mode_d;
            tone_q     <= tone_d;
            alarm_q    <= alarm_d;
        end
    end

    assign alarm_o    = alarm_q;
    assign hr_high_o  = disp_hr[7:4];
    assign hr_low_o   = disp_hr[3:0];
    assign min_high_o = disp_min[7:4];
    assign min_low_o  = disp_min[3:0];
    assign led_hr_o   = set_mode_i & turn_i;
    assign led_min_o  = set_mode_i & ~turn_i;

endmodule

// File: tb/tb_alarm_bank.sv
// tb_alarm_bank: random and directed stimulus checked against a seconds-remaining model of each channel
module tb_alarm_bank;

    localparam int N  = 4;
    localparam int RS = 60;
    localparam int SM = 5;
    localparam int TD = 2;

    logic alarm_clk = 0, rst_n = 0, tick_1hz = 0, set_mode_i = 0, turn_i = 0;
    logic change_i = 0, stop_i = 0, snooze_i = 0;
    logic [1:0] sel_i = 0;
    logic [3:0] en_i = 0;
    logic [3:0] hr_high_i, hr_low_i, min_high_i, min_low_i, sec_high_i, sec_low_i;
    logic       alarm_o, led_hr_o, led_min_o;
    logic [3:0] ringing_o, hr_high_o, hr_low_o, min_high_o, min_low_o;

    int  now = 0, checks = 0, fails = 0;
    bit  chk_on = 0;
    int  ah[N], am[N], rl[N], sl[N];
    int  run = 0;
    bit  m_alarm = 0, pchg = 0, pset = 0;

    assign hr_high_i  = 4'(now / 36000);
    assign hr_low_i   = 4'((now / 3600) % 10);
    assign min_high_i = 4'(((now / 60) % 60) / 10);
    assign min_low_i  = 4'((now / 60) % 10);
    assign sec_high_i = 4'((now % 60) / 10);
    assign sec_low_i  = 4'(now % 10);

    alarm_bank #(.NUM_ALARMS(N), .RING_SECS(RS), .SNOOZE_MIN(SM), .TONE_DIV(TD)) dut (
        .alarm_clk(alarm_clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
        .hr_high_i(hr_high_i), .hr_low_i(hr_low_i), .min_high_i(min_high_i), .min_low_i(min_low_i),
        .sec_high_i(sec_high_i), .sec_low_i(sec_low_i), .sel_i(sel_i), .set_mode_i(set_mode_i),
        .turn_i(turn_i), .change_i(change_i), .en_i(en_i), .stop_i(stop_i), .snooze_i(snooze_i),
        .alarm_o(alarm_o), .ringing_o(ringing_o), .hr_high_o(hr_high_o), .hr_low_o(hr_low_o),
        .min_high_o(min_high_o), .min_low_o(min_low_o), .led_hr_o(led_hr_o), .led_min_o(led_min_o)
    );

    always #5 alarm_clk = ~alarm_clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int model_ring();
        int v = 0;
        for (int k = 0; k < N; k++) if (rl[k] > 0) v |= (1 << k);
        return v;
    endfunction

    // Reference model: per channel, seconds left ringing and seconds left snoozing
    always @(posedge alarm_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                ah[k] = 7; am[k] = 0; rl[k] = 0; sl[k] = 0;
            end
            run = 0; m_alarm = 0; pchg = change_i; pset = set_mode_i;
        end else begin
            run = (model_ring() != 0) ? run + 1 : 0;
            m_alarm = ((run / TD) % 2) == 1;
            for (int k = 0; k < N; k++) begin
                bit m;
                m = tick_1hz && (now % 60 == 0) && !set_mode_i && en_i[k] &&
                    ah[k] == now / 3600 && am[k] == (now / 60) % 60;
                if (!en_i[k] || stop_i) begin
                    rl[k] = 0; sl[k] = 0;
                end else if (rl[k] > 0) begin
                    if (snooze_i) begin rl[k] = 0; sl[k] = SM * 60; end
                    else if (tick_1hz) rl[k]--;
                end else if (sl[k] > 0) begin
                    if (tick_1hz) begin
                        sl[k]--;
                        if (sl[k] == 0 || m) begin sl[k] = 0; rl[k] = RS; end
                    end
                end else if (m) rl[k] = RS;
            end
            if (set_mode_i && set_mode_i == pset && change_i != pchg) begin
                if (turn_i) ah[sel_i] = (ah[sel_i] + 1) % 24;
                else am[sel_i] = (am[sel_i] + 1) % 60;
            end
            pchg = change_i; pset = set_mode_i;
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge alarm_clk) begin
        if (chk_on) begin
            check("ringing", ringing_o, model_ring());
            check("alarm", alarm_o, m_alarm);
            check("disp_hr", {hr_high_o, hr_low_o}, ((ah[sel_i] / 10) << 4) | (ah[sel_i] % 10));
            check("disp_min", {min_high_o, min_low_o}, ((am[sel_i] / 10) << 4) | (am[sel_i] % 10));
            check("led_hr", led_hr_o, set_mode_i & turn_i);
            check("led_min", led_min_o, set_mode_i & ~turn_i);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge alarm_clk);
            #1;
            tick_1hz = 0; stop_i = 0; snooze_i = 0;
        end
    endtask

    task automatic sec_tick(input bit st = 1'b0);
        tick_1hz = 1; stop_i = st;
        step(1);
        now = (now + 1) % 86400;
    endtask

    task automatic inc(input int k, input bit t, input int n);
        sel_i = 2'(k); turn_i = t;
        repeat (n) begin change_i = ~change_i; step(1); end
    endtask

    task automatic edit_to(input int k, input int h, input int m);
        set_mode_i = 1; step(1);
        inc(k, 1, (h - ah[k] + 24) % 24);
        inc(k, 0, (m - am[k] + 60) % 60);
        set_mode_i = 0; step(1);
    endtask

    task automatic check_disp(input string nm, input int k, input int hr, input int mn);
        sel_i = 2'(k); #1;
        check({nm, "_hr"}, {hr_high_o, hr_low_o}, hr);
        check({nm, "_min"}, {min_high_o, min_low_o}, mn);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        step(3);
        chk_on = 1;
        rst_n = 1;
        step(1);
        for (int k = 0; k < N; k++) check_disp("reset", k, 8'h07, 8'h00);
        check("reset_alarm", alarm_o, 0);
        check("reset_ringing", ringing_o, 0);

        // change toggled together with entering edit mode is ignored
        sel_i = 1; set_mode_i = 1; change_i = ~change_i; step(1);
        check_disp("guard", 1, 8'h07, 8'h00);
        set_mode_i = 0; step(1);

        edit_to(2, 23, 59);
        check_disp("ch2_set", 2, 8'h23, 8'h59);
        set_mode_i = 1; step(1);
        inc(2, 1, 1);
        check_disp("hr_wrap", 2, 8'h00, 8'h59);
        inc(2, 0, 1);
        check_disp("min_wrap", 2, 8'h00, 8'h00);
        check_disp("ch1_kept", 1, 8'h07, 8'h00);
        set_mode_i = 0; step(1);

        edit_to(0, 6, 30);
        check_disp("ch0_set", 0, 8'h06, 8'h30);
        en_i = 4'b0001;
        now = 6 * 3600 + 29 * 60 + 59;
        sec_tick(); sec_tick();
        check("ring_start", ringing_o, 4'b0001);
        step(1); check("tone_lo0", alarm_o, 0);
        step(1); check("tone_hi", alarm_o, 1);
        step(2); check("tone_lo1", alarm_o, 0);
        repeat (RS - 1) sec_tick();
        check("ring_last", ringing_o, 4'b0001);
        sec_tick();
        check("ring_timeout", ringing_o, 0);

        now = 6 * 3600 + 29 * 60 + 59;
        sec_tick(); sec_tick();
        check("ring_again", ringing_o, 4'b0001);
        snooze_i = 1; step(1);
        check("snoozed", ringing_o, 0);
        repeat (SM * 60 - 1) sec_tick();
        check("snooze_wait", ringing_o, 0);
        sec_tick();
        check("snooze_expire", ringing_o, 4'b0001);
        stop_i = 1; step(1);
        check("stopped", ringing_o, 0);
        snooze_i = 1; step(1);
        repeat (SM * 60) sec_tick();
        check("idle_snooze", ringing_o, 0);

        edit_to(0, 12, 0);
        edit_to(3, 12, 0);
        en_i = 4'b1001;
        now = 11 * 3600 + 59 * 60 + 59;
        sec_tick(); sec_tick();
        check("two_ring", ringing_o, 4'b1001);
        en_i = 4'b0001; step(1);
        check("en_drop", ringing_o, 4'b0001);
        stop_i = 1; step(1);

        now = 11 * 3600 + 59 * 60 + 59;
        sec_tick(); sec_tick(1'b1);
        check("stop_on_match", ringing_o, 0);
        now = 11 * 3600 + 59 * 60 + 59;
        sec_tick(); set_mode_i = 1; sec_tick();
        check("setmode_block", ringing_o, 0);
        set_mode_i = 0; step(1);

        now = 11 * 3600 + 59 * 60 + 59;
        sec_tick(); sec_tick();
        w = 0;
        while (alarm_o !== 1'b1 && w < 20) begin step(1); w++; end
        check("tone_before_reset", alarm_o, 1);
        #2 rst_n = 0;
        #1;
        check("async_rst_alarm", alarm_o, 0);
        check("async_rst_ring", ringing_o, 0);
        step(2);
        rst_n = 1;
        step(1);

        for (int k = 0; k < N; k++) edit_to(k, $urandom_range(0, 23), $urandom_range(0, 59));
        en_i = 4'hF;
        for (int c = 0; c < 4000; c++) begin
            bit t;
            int r, j;
            t = 1'($urandom_range(0, 1));
            tick_1hz = t;
            r = $urandom_range(0, 199);
            stop_i = (r == 0);
            snooze_i = (r >= 1 && r <= 4);
            if ($urandom_range(0, 59) == 0) en_i = 4'($urandom);
            else if ($urandom_range(0, 29) == 0) en_i = 4'hF;
            if ($urandom_range(0, 79) == 0) begin
                j = $urandom_range(0, N - 1);
                now = (ah[j] * 3600 + am[j] * 60 + 86400 - $urandom_range(0, 2)) % 86400;
            end
            if (set_mode_i ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 199) == 0))
                set_mode_i = ~set_mode_i;
            if (set_mode_i) begin
                sel_i = 2'($urandom); turn_i = 1'($urandom); change_i = 1'($urandom);
            end
            step(1);
            if (t) now = (now + 1) % 86400;
        end
        set_mode_i = 0;
        step(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
